// File: rtl/sb_pkg.sv
// Shared helpers for the SB (valid/ready) stream blocks: default payload width
// and the pointer/occupancy width functions used to size FIFO state.
package sb_pkg;

  localparam int unsigned SB_DATA_W = 8;

  // Pointer width for a power-of-two depth; pointers wrap naturally.
  function automatic int unsigned SB_PTR_W(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Occupancy needs one extra bit to represent the full value DEPTH.
  function automatic int unsigned SB_CNT_W(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit sb_is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/sb_fifo_mem.sv
// Storage array for sb_fifo: one synchronous write port, one asynchronous
// read port, no reset and no control logic.
module sb_fifo_mem
  import sb_pkg::*;
#(
  parameter int unsigned DATA_W = SB_DATA_W,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                        clk_i,
  input  logic                        we,
  input  logic [SB_PTR_W(DEPTH)-1:0]  waddr,
  input  logic [DATA_W-1:0]           wdata,
  input  logic [SB_PTR_W(DEPTH)-1:0]  raddr,
  output logic [DATA_W-1:0]           rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sb_fifo.sv
// Parametrised first-word-fall-through FIFO with SB handshake on both sides.
// Optional almost_full/almost_empty flags are built when SB_FIFO_ALMOST_EN is defined.
module sb_fifo
  import sb_pkg::*;
#(
  parameter int unsigned DATA_W = SB_DATA_W,
  parameter int unsigned DEPTH  = 8
`ifdef SB_FIFO_ALMOST_EN
  ,
  parameter int unsigned AF_TH  = DEPTH - 1,
  parameter int unsigned AE_TH  = 1
`endif
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [SB_CNT_W(DEPTH)-1:0]  count
`ifdef SB_FIFO_ALMOST_EN
  ,
  output logic                        almost_full,
  output logic                        almost_empty
`endif
);

  localparam int unsigned PTR_W = SB_PTR_W(DEPTH);
  localparam int unsigned CNT_W = SB_CNT_W(DEPTH);

  // Elaboration-time parameter checks.
  if (DATA_W < 1) begin : g_data_w_chk
    $error("sb_fifo: DATA_W must be >= 1");
  end
  if ((DEPTH < 2) || !sb_is_pow2(DEPTH)) begin : g_depth_chk
    $error("sb_fifo: DEPTH must be a power of two >= 2");
  end
`ifdef SB_FIFO_ALMOST_EN
  if ((AF_TH == 0) || (AF_TH > DEPTH)) begin : g_af_chk
    $error("sb_fifo: AF_TH must satisfy 0 < AF_TH <= DEPTH");
  end
  if (AE_TH >= DEPTH) begin : g_ae_chk
    $error("sb_fifo: AE_TH must satisfy AE_TH < DEPTH");
  end
`endif

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full_c;
  logic             empty_c;
  logic             push_c;
  logic             pop_c;

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == CNT_W'(0));

  // Handshake depends only on state (and reset), never on same-cycle inputs,
  // so a pop at full frees the slot only on the following cycle.
  assign in_ready  = !full_c && !rst_i;
  assign out_valid = !empty_c;

  assign push_c = in_valid && in_ready;
  assign pop_c  = out_valid && out_ready;

  // Pointer and occupancy state; a reset cycle discards any push or pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  sb_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk_i  (clk_i),
    .we     (push_c),
    .waddr  (wr_ptr),
    .wdata  (in_data),
    .raddr  (rd_ptr),
    .rdata  (out_data)
  );

`ifdef SB_FIFO_ALMOST_EN
  // Thresholds compared in a wider domain so AF_TH = DEPTH needs no special case.
  assign almost_full  = (32'(count) >= AF_TH);
  assign almost_empty = (32'(count) <= AE_TH);
`endif

endmodule

// File: tb/tb_sb_fifo.sv
// Self-checking bench for sb_fifo: a hand-written vector table for the directed
// scenarios plus randomized traffic checked against a queue-based model.
module tb_sb_fifo;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  count;
`ifdef SB_FIFO_ALMOST_EN
  logic              almost_full;
  logic              almost_empty;
`endif

  sb_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .count        (count)
`ifdef SB_FIFO_ALMOST_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] model_q [$];

  typedef struct {
    logic              rst;
    logic              iv;
    logic [DATA_W-1:0] din;
    logic              ordy;
    int                exp_count;
    logic              exp_ov;
    logic              exp_ir;
    logic              chk_data;
    logic [DATA_W-1:0] exp_data;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare against the queue model, clock, update model.
  task automatic cycle(input logic r, input logic iv, input logic [DATA_W-1:0] d,
                       input logic ordy);
    bit m_push;
    bit m_pop;
    rst_i = r; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    chk("model_count", 32'(count), 32'(model_q.size()));
    chk("model_out_valid", 32'(out_valid), 32'(model_q.size() != 0));
    chk("model_in_ready", 32'(in_ready), 32'((model_q.size() != DEPTH) && !r));
    if (model_q.size() != 0) chk("model_out_data", 32'(out_data), 32'(model_q[0]));
`ifdef SB_FIFO_ALMOST_EN
    chk("model_almost_full", 32'(almost_full), 32'(model_q.size() >= DEPTH - 1));
    chk("model_almost_empty", 32'(almost_empty), 32'(model_q.size() <= 1));
`endif
    m_push = iv && (model_q.size() < DEPTH) && !r;
    m_pop  = ordy && (model_q.size() != 0);
    @(posedge clk_i);
    #1;
    if (r) begin
      model_q.delete();
    end else begin
      if (m_pop) void'(model_q.pop_front());
      if (m_push) model_q.push_back(d);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic iv, input logic [DATA_W-1:0] d,
                              input logic ordy, input int ec, input logic eov,
                              input logic eir, input logic cd, input logic [DATA_W-1:0] ed);
    vec_t v;
    v.rst = r; v.iv = iv; v.din = d; v.ordy = ordy;
    v.exp_count = ec; v.exp_ov = eov; v.exp_ir = eir; v.chk_data = cd; v.exp_data = ed;
    return v;
  endfunction

  initial begin
    rst_i = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Idle after reset, fill, overfill attempt, drain, refill, push+pop at full.
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 1, 8'(i + 1), 0, i, i != 0, 1, i != 0, 8'h01));
    vecs.push_back(mk(0, 1, 8'hFF, 0, 8, 1, 0, 1, 8'h01));
    vecs.push_back(mk(0, 1, 8'hFF, 0, 8, 1, 0, 1, 8'h01));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 0, 8'h00, 1, 8 - i, 1, i != 0, 1, 8'(i + 1)));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 1, 8'(8'h10 + i), 0, i, i != 0, 1, i != 0, 8'h10));
    vecs.push_back(mk(0, 1, 8'hEE, 1, 8, 1, 0, 1, 8'h10));
    vecs.push_back(mk(0, 0, 8'h00, 0, 7, 1, 1, 1, 8'h11));

    repeat (2) begin
      @(posedge clk_i);
      #1;
    end
    model_q.delete();
    rst_i = 1'b0;
    #1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef SB_FIFO_ALMOST_EN
    chk("reset_almost_empty", 32'(almost_empty), 32'd1);
    chk("reset_almost_full", 32'(almost_full), 32'd0);
`endif

    foreach (vecs[k]) begin
      rst_i = vecs[k].rst; in_valid = vecs[k].iv; in_data = vecs[k].din;
      out_ready = vecs[k].ordy;
      #1;
      chk($sformatf("vec%0d_count", k), 32'(count), 32'(vecs[k].exp_count));
      chk($sformatf("vec%0d_out_valid", k), 32'(out_valid), 32'(vecs[k].exp_ov));
      chk($sformatf("vec%0d_in_ready", k), 32'(in_ready), 32'(vecs[k].exp_ir));
      if (vecs[k].chk_data)
        chk($sformatf("vec%0d_out_data", k), 32'(out_data), 32'(vecs[k].exp_data));
      cycle(vecs[k].rst, vecs[k].iv, vecs[k].din, vecs[k].ordy);
    end

    // Streaming with occupancy held at 3; pointers wrap twice over 20 words.
    cycle(1, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'(i), 0);
    for (int i = 3; i < 20; i++) begin
      chk("stream_count", 32'(count), 32'd3);
      chk("stream_out_data", 32'(out_data), 32'(i - 3));
      cycle(0, 1, 8'(i), 1);
    end
    for (int i = 17; i < 20; i++) begin
      chk("stream_tail_data", 32'(out_data), 32'(i));
      cycle(0, 0, 8'h00, 1);
    end
    chk("stream_empty", 32'(out_valid), 32'd0);

    // Mid-operation reset while pushing 0xAA: all words and the push are discarded.
    for (int i = 0; i < 5; i++) cycle(0, 1, 8'(8'h30 + i), 0);
    chk("midrst_pre_count", 32'(count), 32'd5);
    cycle(1, 1, 8'hAA, 1);
    rst_i = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    cycle(0, 1, 8'h55, 0);
    chk("midrst_first_word", 32'(out_data), 32'h55);
    cycle(0, 0, 8'h00, 1);
    chk("midrst_drained", 32'(out_valid), 32'd0);

    // Randomized traffic with occasional resets against the queue model.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
            8'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
